// File: rtl/combat_arbiter.sv
// Fight referee for two player_attack instances: resolves one hit per attack window,
// applies damage/hitstun, gates each player's enables and runs the IDLE/FIGHT/KO round.
module combat_arbiter #(
    parameter int HEALTH_MAX       = 100,
    parameter int ATK1_DAMAGE      = 8,
    parameter int ATK2_DAMAGE      = 15,
    parameter int HITSTUN_FRAMES   = 12,
    parameter int BLOCKSTUN_FRAMES = 4,
    parameter int KO_HOLD_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       SCEN,
    input  logic       start,
    input  logic       p1_attack_active,
    input  logic [1:0] p1_attack_type,
    input  logic       p2_attack_active,
    input  logic [1:0] p2_attack_type,
    input  logic       p1_hits_p2_range,
    input  logic       p2_hits_p1_range,
    input  logic       p1_block,
    input  logic       p2_block,
    output logic       p1_attack_enable,
    output logic       p1_move_enable,
    output logic       p2_attack_enable,
    output logic       p2_move_enable,
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic [1:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIGHT = 2'd1,
        S_KO    = 2'd2
    } state_t;

    localparam logic [6:0] LP_HEALTH_MAX = 7'(HEALTH_MAX);
    localparam logic [6:0] LP_ATK1       = 7'(ATK1_DAMAGE);
    localparam logic [6:0] LP_ATK2       = 7'(ATK2_DAMAGE);
    localparam logic [5:0] LP_HITSTUN    = 6'(HITSTUN_FRAMES);
    localparam logic [5:0] LP_BLOCKSTUN  = 6'(BLOCKSTUN_FRAMES);
    localparam logic [7:0] LP_KO_HOLD    = 8'(KO_HOLD_FRAMES);
    localparam logic [7:0] LP_KO_ACCEPT  = 8'(KO_HOLD_FRAMES - 1);

    state_t     r_state,     w_state_next;
    logic [6:0] r_p1_health, w_p1_health_next;
    logic [6:0] r_p2_health, w_p2_health_next;
    logic [5:0] r_p1_stun,   w_p1_stun_next;
    logic [5:0] r_p2_stun,   w_p2_stun_next;
    logic       r_p1_latch,  w_p1_latch_next;
    logic       r_p2_latch,  w_p2_latch_next;
    logic [7:0] r_ko_cnt,    w_ko_cnt_next;
    logic [1:0] r_winner,    w_winner_next;
    logic       r_p1_en,     w_p1_en_next;
    logic       r_p2_en,     w_p2_en_next;
    logic       r_p1_hit,    w_p1_hit_next;
    logic       r_p2_hit,    w_p2_hit_next;

    // w_p1_qual: P1 lands a hit on P2 this frame (and vice versa for w_p2_qual)
    logic       w_p1_qual,       w_p2_qual;
    logic [6:0] w_p1_base,       w_p2_base;
    logic       w_p1_guard,      w_p2_guard;
    logic [6:0] w_dmg_to_p1,     w_dmg_to_p2;
    logic [6:0] w_p1_health_hit, w_p2_health_hit;
    logic [5:0] w_p1_stun_dec,   w_p2_stun_dec;
    logic       w_reload;

    assign w_p1_qual = p1_attack_active && (p1_attack_type == 2'd1 || p1_attack_type == 2'd2)
                       && p1_hits_p2_range && !r_p1_latch && (r_p1_stun == 6'd0);
    assign w_p2_qual = p2_attack_active && (p2_attack_type == 2'd1 || p2_attack_type == 2'd2)
                       && p2_hits_p1_range && !r_p2_latch && (r_p2_stun == 6'd0);

    assign w_p1_base = (p1_attack_type == 2'd2) ? LP_ATK2 : LP_ATK1;
    assign w_p2_base = (p2_attack_type == 2'd2) ? LP_ATK2 : LP_ATK1;

    // A guard only counts when the victim is not already reeling from a hit.
    assign w_p1_guard = p1_block && (r_p1_stun == 6'd0);
    assign w_p2_guard = p2_block && (r_p2_stun == 6'd0);

    assign w_dmg_to_p1 = w_p1_guard ? (w_p2_base >> 1) : w_p2_base;
    assign w_dmg_to_p2 = w_p2_guard ? (w_p1_base >> 1) : w_p1_base;

    assign w_p1_health_hit = (r_p1_health <= w_dmg_to_p1) ? 7'd0 : (r_p1_health - w_dmg_to_p1);
    assign w_p2_health_hit = (r_p2_health <= w_dmg_to_p2) ? 7'd0 : (r_p2_health - w_dmg_to_p2);

    assign w_p1_stun_dec = (r_p1_stun != 6'd0) ? (r_p1_stun - 6'd1) : 6'd0;
    assign w_p2_stun_dec = (r_p2_stun != 6'd0) ? (r_p2_stun - 6'd1) : 6'd0;

    assign w_reload = SCEN && start &&
                      ((r_state == S_IDLE) || ((r_state == S_KO) && (r_ko_cnt >= LP_KO_ACCEPT)));

    always_comb begin
        w_state_next     = r_state;
        w_p1_health_next = r_p1_health;
        w_p2_health_next = r_p2_health;
        w_p1_stun_next   = r_p1_stun;
        w_p2_stun_next   = r_p2_stun;
        w_p1_latch_next  = r_p1_latch;
        w_p2_latch_next  = r_p2_latch;
        w_ko_cnt_next    = r_ko_cnt;
        w_winner_next    = r_winner;
        w_p1_en_next     = r_p1_en;
        w_p2_en_next     = r_p2_en;
        w_p1_hit_next    = r_p1_hit;
        w_p2_hit_next    = r_p2_hit;

        if (SCEN) begin
            w_p1_hit_next = 1'b0;
            w_p2_hit_next = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_p1_en_next = 1'b0;
                    w_p2_en_next = 1'b0;
                end
                S_FIGHT: begin
                    w_p1_health_next = w_p2_qual ? w_p1_health_hit : r_p1_health;
                    w_p2_health_next = w_p1_qual ? w_p2_health_hit : r_p2_health;
                    w_p1_stun_next   = w_p2_qual ? (w_p1_guard ? LP_BLOCKSTUN : LP_HITSTUN)
                                                 : w_p1_stun_dec;
                    w_p2_stun_next   = w_p1_qual ? (w_p2_guard ? LP_BLOCKSTUN : LP_HITSTUN)
                                                 : w_p2_stun_dec;
                    w_p1_latch_next  = p1_attack_active && (r_p1_latch || w_p1_qual);
                    w_p2_latch_next  = p2_attack_active && (r_p2_latch || w_p2_qual);
                    w_p1_hit_next    = w_p2_qual;
                    w_p2_hit_next    = w_p1_qual;
                    if (w_p1_health_next == 7'd0 || w_p2_health_next == 7'd0) begin
                        w_state_next  = S_KO;
                        w_ko_cnt_next = 8'd0;
                        w_winner_next = {w_p1_health_next == 7'd0, w_p2_health_next == 7'd0};
                        w_p1_en_next  = 1'b0;
                        w_p2_en_next  = 1'b0;
                    end else begin
                        w_p1_en_next = (w_p1_stun_next == 6'd0);
                        w_p2_en_next = (w_p2_stun_next == 6'd0);
                    end
                end
                S_KO: begin
                    w_p1_en_next = 1'b0;
                    w_p2_en_next = 1'b0;
                    if (r_ko_cnt < LP_KO_HOLD) begin
                        w_ko_cnt_next = r_ko_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            if (w_reload) begin
                w_state_next     = S_FIGHT;
                w_p1_health_next = LP_HEALTH_MAX;
                w_p2_health_next = LP_HEALTH_MAX;
                w_p1_stun_next   = 6'd0;
                w_p2_stun_next   = 6'd0;
                w_p1_latch_next  = 1'b0;
                w_p2_latch_next  = 1'b0;
                w_ko_cnt_next    = 8'd0;
                w_winner_next    = 2'd0;
                w_p1_en_next     = 1'b1;
                w_p2_en_next     = 1'b1;
                w_p1_hit_next    = 1'b0;
                w_p2_hit_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_p1_health <= LP_HEALTH_MAX;
            r_p2_health <= LP_HEALTH_MAX;
            r_p1_stun   <= 6'd0;
            r_p2_stun   <= 6'd0;
            r_p1_latch  <= 1'b0;
            r_p2_latch  <= 1'b0;
            r_ko_cnt    <= 8'd0;
            r_winner    <= 2'd0;
            r_p1_en     <= 1'b0;
            r_p2_en     <= 1'b0;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_p1_health <= w_p1_health_next;
            r_p2_health <= w_p2_health_next;
            r_p1_stun   <= w_p1_stun_next;
            r_p2_stun   <= w_p2_stun_next;
            r_p1_latch  <= w_p1_latch_next;
            r_p2_latch  <= w_p2_latch_next;
            r_ko_cnt    <= w_ko_cnt_next;
            r_winner    <= w_winner_next;
            r_p1_en     <= w_p1_en_next;
            r_p2_en     <= w_p2_en_next;
            r_p1_hit    <= w_p1_hit_next;
            r_p2_hit    <= w_p2_hit_next;
        end
    end

    assign p1_attack_enable = r_p1_en;
    assign p1_move_enable   = r_p1_en;
    assign p2_attack_enable = r_p2_en;
    assign p2_move_enable   = r_p2_en;
    assign p1_health        = r_p1_health;
    assign p2_health        = r_p2_health;
    assign p1_hit           = r_p1_hit;
    assign p2_hit           = r_p2_hit;
    assign game_state       = r_state;
    assign winner           = r_winner;

endmodule

// File: tb/tb_combat_arbiter.sv
// Bench for combat_arbiter: directed fight scenarios, a frame-level referee model
// compared on every clock, plus hand-computed literal expectations.
module tb_combat_arbiter;

    localparam int HMAX = 100;
    localparam int A1   = 8;
    localparam int A2   = 15;
    localparam int HS   = 12;
    localparam int BS   = 4;
    localparam int KOH  = 60;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       scen = 1'b0;
    logic       start = 1'b0;
    logic       p1_act = 1'b0;
    logic [1:0] p1_type = 2'd0;
    logic       p2_act = 1'b0;
    logic [1:0] p2_type = 2'd0;
    logic       r12 = 1'b0;
    logic       r21 = 1'b0;
    logic       b1 = 1'b0;
    logic       b2 = 1'b0;

    logic       p1_attack_enable, p1_move_enable, p2_attack_enable, p2_move_enable;
    logic [6:0] p1_health, p2_health;
    logic       p1_hit, p2_hit;
    logic [1:0] game_state, winner;

    combat_arbiter #(
        .HEALTH_MAX(HMAX), .ATK1_DAMAGE(A1), .ATK2_DAMAGE(A2),
        .HITSTUN_FRAMES(HS), .BLOCKSTUN_FRAMES(BS), .KO_HOLD_FRAMES(KOH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .SCEN(scen), .start(start),
        .p1_attack_active(p1_act), .p1_attack_type(p1_type),
        .p2_attack_active(p2_act), .p2_attack_type(p2_type),
        .p1_hits_p2_range(r12), .p2_hits_p1_range(r21),
        .p1_block(b1), .p2_block(b2),
        .p1_attack_enable(p1_attack_enable), .p1_move_enable(p1_move_enable),
        .p2_attack_enable(p2_attack_enable), .p2_move_enable(p2_move_enable),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .game_state(game_state), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- referee model (frame level, integer arithmetic) ----------------
    int m_state = 0, m_h1 = HMAX, m_h2 = HMAX, m_s1 = 0, m_s2 = 0;
    int m_winner = 0, m_ko_frames = 0;
    bit m_l1 = 0, m_l2 = 0, m_hit1 = 0, m_hit2 = 0;
    bit q12, q21;
    int d, ns1, ns2;

    task automatic model_new_round();
        m_state = 1; m_h1 = HMAX; m_h2 = HMAX; m_s1 = 0; m_s2 = 0;
        m_l1 = 0; m_l2 = 0; m_winner = 0; m_ko_frames = 0;
        m_hit1 = 0; m_hit2 = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_state = 0; m_h1 = HMAX; m_h2 = HMAX; m_s1 = 0; m_s2 = 0;
            m_l1 = 0; m_l2 = 0; m_winner = 0; m_ko_frames = 0; m_hit1 = 0; m_hit2 = 0;
        end else if (scen) begin
            m_hit1 = 0; m_hit2 = 0;
            if (m_state == 0) begin
                if (start) model_new_round();
            end else if (m_state == 1) begin
                q12 = p1_act && (p1_type == 1 || p1_type == 2) && r12 && !m_l1 && m_s1 == 0;
                q21 = p2_act && (p2_type == 1 || p2_type == 2) && r21 && !m_l2 && m_s2 == 0;
                ns1 = (m_s1 > 0) ? m_s1 - 1 : 0;
                ns2 = (m_s2 > 0) ? m_s2 - 1 : 0;
                if (q12) begin
                    d = (p1_type == 2) ? A2 : A1;
                    if (b2 && m_s2 == 0) begin d = d / 2; ns2 = BS; end
                    else ns2 = HS;
                    m_h2 = (m_h2 > d) ? m_h2 - d : 0;
                    m_hit2 = 1;
                end
                if (q21) begin
                    d = (p2_type == 2) ? A2 : A1;
                    if (b1 && m_s1 == 0) begin d = d / 2; ns1 = BS; end
                    else ns1 = HS;
                    m_h1 = (m_h1 > d) ? m_h1 - d : 0;
                    m_hit1 = 1;
                end
                m_s1 = ns1; m_s2 = ns2;
                if (!p1_act) m_l1 = 0; else if (q12) m_l1 = 1;
                if (!p2_act) m_l2 = 0; else if (q21) m_l2 = 1;
                if (m_h1 == 0 || m_h2 == 0) begin
                    m_state = 2;
                    m_ko_frames = 0;
                    if (m_h1 == 0 && m_h2 == 0) m_winner = 3;
                    else if (m_h2 == 0) m_winner = 1;
                    else m_winner = 2;
                end
            end else begin
                m_ko_frames++;
                if (start && m_ko_frames >= KOH) model_new_round();
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("cmp_state",  32'(game_state), 32'(m_state));
            check("cmp_p1_hp",  32'(p1_health), 32'(m_h1));
            check("cmp_p2_hp",  32'(p2_health), 32'(m_h2));
            check("cmp_winner", 32'(winner), 32'(m_winner));
            check("cmp_p1_hit", 32'(p1_hit), 32'(m_hit1));
            check("cmp_p2_hit", 32'(p2_hit), 32'(m_hit2));
            check("cmp_p1_aen", 32'(p1_attack_enable), 32'(m_state == 1 && m_s1 == 0));
            check("cmp_p1_men", 32'(p1_move_enable),   32'(m_state == 1 && m_s1 == 0));
            check("cmp_p2_aen", 32'(p2_attack_enable), 32'(m_state == 1 && m_s2 == 0));
            check("cmp_p2_men", 32'(p2_move_enable),   32'(m_state == 1 && m_s2 == 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One frame: a SCEN cycle with the given inputs, then a non-SCEN cycle of junk.
    task automatic frame(input logic st,
                         input logic a1, input logic [1:0] t1, input logic x12, input logic k1,
                         input logic a2, input logic [1:0] t2, input logic x21, input logic k2);
        @(negedge clk);
        start = st; p1_act = a1; p1_type = t1; r12 = x12; b1 = k1;
        p2_act = a2; p2_type = t2; r21 = x21; b2 = k2; scen = 1'b1;
        @(negedge clk);
        scen = 1'b0;
        start = 1'($urandom); p1_act = 1'($urandom); p1_type = 2'($urandom);
        p2_act = 1'($urandom); p2_type = 2'($urandom); r12 = 1'($urandom);
        r21 = 1'($urandom); b1 = 1'($urandom); b2 = 1'($urandom);
    endtask

    task automatic idle(input int n, input logic st);
        repeat (n) frame(st, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic p1_strike(input logic [1:0] t, input logic blk2);
        frame(0, 1, t, 1, 0, 0, 2'd0, 0, blk2);
        idle(1, 0);
    endtask

    task automatic p2_strike(input logic [1:0] t);
        frame(0, 0, 2'd0, 0, 0, 1, t, 1, 0);
        idle(1, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int low_cnt;

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(game_state), 32'd0);
        check("reset_p1_hp", 32'(p1_health), 32'd100);
        check("reset_p2_hp", 32'(p2_health), 32'd100);
        check("reset_enables", 32'({p1_attack_enable, p1_move_enable, p2_attack_enable, p2_move_enable}), 32'd0);
        check("reset_winner", 32'(winner), 32'd0);
        reset_n = 1'b1;

        // Basic hit
        idle(1, 0);
        check("idle_no_start", 32'(game_state), 32'd0);
        idle(1, 1);
        check("start_state", 32'(game_state), 32'd1);
        check("start_enables", 32'({p1_attack_enable, p1_move_enable, p2_attack_enable, p2_move_enable}), 32'hF);
        frame(0, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0);
        frame(0, 1, 2'd3, 1, 0, 0, 2'd0, 0, 0);
        idle(1, 0);
        check("type0_3_no_dmg", 32'(p2_health), 32'd100);
        frame(0, 1, 2'd1, 1, 0, 0, 2'd0, 0, 0);
        check("basic_p2_hp", 32'(p2_health), 32'd92);
        check("basic_p2_hit", 32'(p2_hit), 32'd1);
        low_cnt = p2_move_enable ? 0 : 1;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) frame(0, 1, 2'd1, 1, 0, 0, 2'd0, 0, 0);
            else idle(1, 0);
            if (i == 0) check("basic_pulse_once", 32'(p2_hit), 32'd0);
            if (!p2_move_enable) low_cnt++;
        end
        check("basic_hp_once", 32'(p2_health), 32'd92);
        check("basic_stun_frames", 32'(low_cnt), 32'd12);

        // Blocked hit
        frame(0, 0, 2'd0, 0, 1, 1, 2'd2, 1, 0);
        check("block_p1_hp", 32'(p1_health), 32'd93);
        low_cnt = p1_attack_enable ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            idle(1, 0);
            if (!p1_attack_enable) low_cnt++;
        end
        check("block_stun_frames", 32'(low_cnt), 32'd4);

        // Trade
        pulse_reset();
        idle(1, 1);
        frame(0, 1, 2'd1, 1, 0, 1, 2'd2, 1, 0);
        check("trade_p1_hp", 32'(p1_health), 32'd85);
        check("trade_p2_hp", 32'(p2_health), 32'd92);
        check("trade_pulses", 32'({p1_hit, p2_hit}), 32'd3);
        idle(15, 0);

        // Saturation and KO (later strikes guard while stunned: full damage)
        for (int i = 0; i < 9; i++) p1_strike(2'd1, (i != 0));
        p1_strike(2'd2, 1);
        check("preload_p2_hp", 32'(p2_health), 32'd5);
        frame(0, 1, 2'd2, 1, 0, 0, 2'd0, 0, 0);
        check("ko_p2_hp", 32'(p2_health), 32'd0);
        check("ko_state", 32'(game_state), 32'd2);
        check("ko_winner", 32'(winner), 32'd1);
        check("ko_enables", 32'({p1_attack_enable, p1_move_enable, p2_attack_enable, p2_move_enable}), 32'd0);
        check("ko_p1_hp_hold", 32'(p1_health), 32'd85);
        idle(59, 1);
        check("ko_start_ignored", 32'(game_state), 32'd2);
        idle(1, 1);
        check("ko_restart_state", 32'(game_state), 32'd1);
        check("ko_restart_hp", 32'({p1_health, p2_health}), 32'({7'd100, 7'd100}));
        check("ko_restart_winner", 32'(winner), 32'd0);

        // Draw
        for (int i = 0; i < 4; i++) p1_strike(2'd2, 0);
        for (int i = 0; i < 4; i++) p1_strike(2'd1, 0);
        check("draw_p2_pre", 32'(p2_health), 32'd8);
        idle(13, 0);
        for (int i = 0; i < 4; i++) p2_strike(2'd2);
        for (int i = 0; i < 4; i++) p2_strike(2'd1);
        check("draw_p1_pre", 32'(p1_health), 32'd8);
        idle(13, 0);
        frame(0, 1, 2'd1, 1, 0, 1, 2'd1, 1, 0);
        check("draw_hp", 32'({p1_health, p2_health}), 32'd0);
        check("draw_winner", 32'(winner), 32'd3);
        check("draw_state", 32'(game_state), 32'd2);

        // Hitstun gating and asynchronous reset
        pulse_reset();
        idle(1, 1);
        frame(0, 0, 2'd0, 0, 0, 1, 2'd1, 1, 0);
        check("gate_p1_hp", 32'(p1_health), 32'd92);
        frame(0, 1, 2'd2, 1, 0, 0, 2'd0, 0, 0);
        check("gate_no_dmg", 32'(p2_health), 32'd100);
        #2 reset_n = 1'b0;
        #1;
        check("async_state", 32'(game_state), 32'd0);
        check("async_hp", 32'({p1_health, p2_health}), 32'({7'd100, 7'd100}));
        check("async_outs", 32'({p1_attack_enable, p1_move_enable, p2_attack_enable,
                                 p2_move_enable, p1_hit, p2_hit, winner}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
